// File: rtl/ln_top.sv
// Fixed-point -ln(x) unit: Q16.16 input in (0, 1.0], Q16.16 result.
// Shift-and-add multiplicative normalization with a start/busy/done handshake.
module ln_top #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 32,
   parameter int ITERS     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 svm_enable,
   input  logic                 start,
   input  logic [IN_WIDTH-1:0]  x_in,
   output logic [OUT_WIDTH-1:0] y_out,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int                  KW    = $clog2(ITERS + 1);
   localparam logic [IN_WIDTH-1:0] X_ONE = IN_WIDTH'(32'h0001_0000);
   localparam logic [48:0]         P_ONE = 49'h1_0000_0000;
   localparam logic [31:0]         Y_SAT = 32'h000B_1721;

   // s*ln2 in Q16.16 for the normalization shift s
   localparam logic [31:0] LN2_TBL [16] = '{
      32'h00000, 32'h0B172, 32'h162E4, 32'h21456,
      32'h2C5C8, 32'h3773A, 32'h428AC, 32'h4DA1E,
      32'h58B90, 32'h63D02, 32'h6EE74, 32'h79FE6,
      32'h85158, 32'h902CA, 32'h9B43C, 32'hA65AE
   };

   typedef enum logic [1:0] {S_IDLE, S_NORM, S_ITER, S_FIN} state_t;

   state_t        r_state, w_state_n;
   logic [16:0]   r_x, w_x_n;
   logic [47:0]   r_p, w_p_n;
   logic [31:0]   r_acc, w_acc_n;
   logic [31:0]   r_y, w_y_n;
   logic [KW-1:0] r_k, w_k_n;
   logic          r_busy, w_busy_n;
   logic          r_done, w_done_n;
   logic          r_err, w_err_n;

   logic [3:0]    w_s;
   logic [16:0]   w_xn;
   logic [48:0]   w_t;
   logic          w_take;

   // round(ln(1 + 2^-k) * 2^16)
   function automatic logic [31:0] ln1p(input logic [KW-1:0] k);
      int kk;
      kk = int'(k);
      case (kk)
         1:       ln1p = 32'h67CD;
         2:       ln1p = 32'h3920;
         3:       ln1p = 32'h1E27;
         4:       ln1p = 32'h0F85;
         5:       ln1p = 32'h07E1;
         6:       ln1p = 32'h03F8;
         7:       ln1p = 32'h01FE;
         8:       ln1p = 32'h0100;
         default: ln1p = (kk >= 9 && kk <= 16) ? (32'h1 << (16 - kk)) : 32'h0;
      endcase
   endfunction

   // Shift that brings the operand into [0.5, 1.0]; the highest set bit wins.
   always_comb begin
      w_s = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (r_x[i]) w_s = 4'(15 - i);
      end
      if (r_x[16]) w_s = 4'd0;
   end

   assign w_xn   = r_x << w_s;
   // 49-bit sum so the compare against 1.0 cannot wrap
   assign w_t    = {1'b0, r_p} + {1'b0, (r_p >> r_k)};
   assign w_take = (w_t <= P_ONE);

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      w_state_n = r_state;
      w_x_n     = r_x;
      w_p_n     = r_p;
      w_acc_n   = r_acc;
      w_k_n     = r_k;
      w_y_n     = r_y;
      w_busy_n  = r_busy;
      w_err_n   = r_err;
      w_done_n  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_x_n = x_in[16:0];
               if (x_in == '0) begin
                  w_y_n    = Y_SAT;
                  w_err_n  = 1'b1;
                  w_done_n = 1'b1;
               end else if (x_in > X_ONE) begin
                  w_y_n    = 32'h0;
                  w_err_n  = 1'b1;
                  w_done_n = 1'b1;
               end else begin
                  w_busy_n  = 1'b1;
                  w_state_n = S_NORM;
               end
            end
         end
         S_NORM: begin
            w_p_n     = {15'h0, w_xn, 16'h0};
            w_acc_n   = LN2_TBL[w_s];
            w_k_n     = KW'(1);
            w_state_n = S_ITER;
         end
         S_ITER: begin
            if (w_take) begin
               w_p_n   = w_t[47:0];
               w_acc_n = r_acc + ln1p(r_k);
            end
            if (r_k == KW'(ITERS)) begin
               // Result is registered on the way into FIN so it is valid while done is high.
               w_y_n     = w_acc_n;
               w_err_n   = 1'b0;
               w_done_n  = 1'b1;
               w_busy_n  = 1'b0;
               w_state_n = S_FIN;
            end else begin
               w_k_n = r_k + KW'(1);
            end
         end
         S_FIN:   w_state_n = S_IDLE;
         default: w_state_n = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_p     <= '0;
         r_acc   <= '0;
         r_k     <= '0;
         r_y     <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else if (svm_enable) begin
         r_state <= w_state_n;
         r_x     <= w_x_n;
         r_p     <= w_p_n;
         r_acc   <= w_acc_n;
         r_k     <= w_k_n;
         r_y     <= w_y_n;
         r_busy  <= w_busy_n;
         r_done  <= w_done_n;
         r_err   <= w_err_n;
      end
   end

   assign y_out = OUT_WIDTH'(r_y);
   assign busy  = r_busy;
   // A frozen pulse stays pending but is never presented while disabled.
   assign done  = r_done & svm_enable;
   assign err   = r_err;

endmodule

// File: tb/tb_ln_top.sv
// Directed bench for ln_top: scoreboard of expected results, checked on each done pulse.
module tb_ln_top;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        svm_enable;
   logic        start;
   logic [31:0] x_in;
   logic [31:0] y_out;
   logic        busy;
   logic        done;
   logic        err;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] y;
      logic        err;
      int          tol;
      int          lat;
      int          bcnt;
      string       tag;
   } exp_t;

   exp_t sb[$];

   ln_top #(.IN_WIDTH(32), .OUT_WIDTH(32), .ITERS(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .svm_enable (svm_enable),
      .start      (start),
      .x_in       (x_in),
      .y_out      (y_out),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv, input int tol);
      logic ok;
      int   d;
      d  = (obs > expv) ? int'(obs - expv) : int'(expv - obs);
      ok = (tol == 0) ? (obs === expv) : (!$isunknown(obs) && d <= tol);
      n_cmp++;
      assert (ok === 1'b1) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h tol=%0d", tag, obs, expv, tol);
      end
   endtask

   // mode 0: plain; 1: extra start while busy; 2: svm_enable low for 5 cycles mid-ITER
   task automatic do_op(input logic [31:0] x, input logic [31:0] ey, input logic eerr, input int tol,
                        input int elat, input int ebusy, input int mode, input string tag);
      exp_t e;
      int   lat;
      int   bcnt;
      sb.push_back('{y: ey, err: eerr, tol: tol, lat: elat, bcnt: ebusy, tag: tag});
      @(negedge clk);
      start = 1'b1;
      x_in  = x;
      @(negedge clk);
      start = 1'b0;
      x_in  = $urandom;
      lat   = 0;
      bcnt  = 0;
      for (int i = 1; i <= 100; i++) begin
         if (mode == 1 && i == 4) begin
            start = 1'b1;
            x_in  = 32'h0001_0000;
         end
         if (mode == 1 && i == 5)  start = 1'b0;
         if (mode == 2 && i == 5)  svm_enable = 1'b0;
         if (mode == 2 && i == 10) svm_enable = 1'b1;
         if (done === 1'b1) begin
            lat = i;
            break;
         end
         if (busy === 1'b1) bcnt++;
         @(negedge clk);
      end
      e = sb.pop_front();
      check({e.tag, " y_out"},   y_out,              e.y,               e.tol);
      check({e.tag, " err"},     {31'h0, err},       {31'h0, e.err},    0);
      check({e.tag, " latency"}, 32'(lat),           32'(e.lat),        0);
      check({e.tag, " busy"},    32'(bcnt),          32'(e.bcnt),       0);
   endtask

   task automatic count_done(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done === 1'b1) cnt++;
      end
   endtask

   initial begin
      int   extra;
      rst_n      = 1'b0;
      svm_enable = 1'b1;
      start      = 1'b0;
      x_in       = '0;
      repeat (3) @(negedge clk);
      check("reset y_out", y_out,          32'h0, 0);
      check("reset busy",  {31'h0, busy},  32'h0, 0);
      check("reset done",  {31'h0, done},  32'h0, 0);
      check("reset err",   {31'h0, err},   32'h0, 0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(32'h0001_0000, 32'h0000_0000, 1'b0, 0, 18, 17, 0, "x=1.0");
      do_op(32'h0000_8000, 32'h0000_B172, 1'b0, 4, 18, 17, 0, "x=0.5");
      do_op(32'h0000_5E2D, 32'h0001_0000, 1'b0, 4, 18, 17, 0, "x=e^-1");
      do_op(32'h0000_0001, 32'h000B_1721, 1'b0, 4, 18, 17, 0, "x=lsb");
      do_op(32'h0000_C000, 32'h0000_49A6, 1'b0, 4, 18, 17, 0, "x=0.75");
      do_op(32'h0000_0000, 32'h000B_1721, 1'b1, 0, 1, 0, 0, "x=0");
      do_op(32'h0001_0001, 32'h0000_0000, 1'b1, 0, 1, 0, 0, "x>1");
      do_op(32'h8000_0000, 32'h0000_0000, 1'b1, 0, 1, 0, 0, "x huge");

      do_op(32'h0000_8000, 32'h0000_B172, 1'b0, 4, 18, 17, 1, "ignore start");
      count_done(25, extra);
      check("ignored start no done", 32'(extra), 32'h0, 0);
      check("ignored start hold y",  y_out,      32'h0000_B172, 4);

      do_op(32'h0000_8000, 32'h0000_B172, 1'b0, 4, 23, 22, 2, "freeze");

      @(negedge clk);
      start = 1'b1;
      x_in  = 32'h0000_4000;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst busy",  {31'h0, busy}, 32'h0, 0);
      check("midrst done",  {31'h0, done}, 32'h0, 0);
      check("midrst y_out", y_out,         32'h0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      count_done(25, extra);
      check("midrst no done", 32'(extra), 32'h0, 0);
      do_op(32'h0000_8000, 32'h0000_B172, 1'b0, 4, 18, 17, 0, "after reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ln_top.md
Name: ln_top

Overview:
- Fixed-point natural-log unit, the inverse of the SVM exponential block.
- Takes x in Q16.16 with 0 < x <= 1.0 and returns y = -ln(x) in Q16.16.
- Feeds kernel-value inversion and calibration paths that must map exp-domain results back to the linear domain.
- Iterative shift-and-add multiplicative normalization; fixed latency; start/busy/done handshake gated by svm_enable.

Parameters:
- IN_WIDTH, 32, width of x_in (Q16.16).
- OUT_WIDTH, 32, width of y_out (Q16.16).
- ITERS, 16, number of refinement iterations k=1..ITERS.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- svm_enable  input  1  global enable; when 0, the FSM holds its state and all registers hold.
- start  input  1  one-cycle request; x_in is sampled when start=1 in IDLE.
- x_in  input  IN_WIDTH  operand, Q16.16.
- y_out  output  OUT_WIDTH  result -ln(x), Q16.16, held until the next completion.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; y_out and err are valid in that cycle.
- err  output  1  range flag for the last result; held with y_out.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - y_out=0, busy=0, done=0, err=0.
  - Internal p=0, acc=0, k=0.
  - Asserting reset mid-operation aborts the operation immediately; no done pulse is produced.
- States: IDLE -> NORM -> ITER -> FIN -> IDLE.
- IDLE, start=1 and svm_enable=1:
  - Latch x_in.
  - If x_in == 0: y_out=0x000B1721 (16*ln2, saturated), err=1, done=1, stay in IDLE.
  - If x_in > 0x00010000: y_out=0, err=1, done=1, stay in IDLE.
  - Otherwise: busy=1, go to NORM.
  - In both error cases done fires in the cycle after start.
- NORM (1 cycle):
  - s = leading-shift count (0..15) such that bit 16 or bit 15 of (x<<s) is set.
  - p = (x<<s) zero-extended to 48 bits as Q16.32 (x<<(s+16)).
  - acc = s*ln2, taken from the 16-entry table s*0xB172 (entries 0, 0xB172, 0x162E4, ... exact products).
  - k=1. Go to ITER.
- ITER (ITERS cycles, one k per cycle):
  - t = p + (p>>k).
  - If t <= 2^32 (1.0 in Q16.32): p=t, acc += LN1P[k].
  - Otherwise p and acc are unchanged.
  - k increments; after k=ITERS go to FIN.
- LN1P[k] = round(ln(1+2^-k)*2^16):
  - k=1..8: 0x67CD, 0x3920, 0x1E27, 0x0F85, 0x07E1, 0x03F8, 0x01FE, 0x0100.
  - k>=9: 2^(16-k).
- FIN (1 cycle): y_out=acc[31:0], err=0, done=1, busy=0, go to IDLE.
- Latency: start accepted at edge T -> done high in cycle T+ITERS+2 (18 cycles at default).
- start while busy is ignored (no queueing).
- svm_enable=0 mid-operation freezes state, p, acc, k and outputs; resuming continues with no loss. done is never asserted while svm_enable=0.
- Widths:
  - acc is 32-bit unsigned; maximum value about 0x000B1721, so there is no overflow.
  - p is 48-bit; t is computed at 49 bits so the compare cannot wrap.
- Accuracy: |y_out - exact| <= 4 LSB over the full valid range.

Test Plan:
- x_in=0x00010000 (1.0) -> done after 18 cycles, y_out=0x00000000, err=0.
- x_in=0x00008000 (0.5) -> y_out=0x0000B172 ±4, err=0; busy high for exactly 17 cycles.
- x_in=0x00005E2D (e^-1) -> y_out=0x00010000 ±4; x_in=0x00000001 -> y_out=0x000B1721 ±4.
- x_in=0 -> done next cycle, y_out=0x000B1721, err=1; x_in=0x00010001 -> y_out=0, err=1.
- Error cases: confirm no busy assertion in either.
- Hold and ignore: start pulse during busy is ignored, and the original result is unchanged.
- Freeze: svm_enable=0 for 5 cycles mid-ITER -> done delayed by exactly 5 cycles, same y_out.
- Reset mid-ITER: rst_n low -> busy=0, done=0, y_out=0 immediately; a subsequent start with 0x8000 yields 0x0000B172 ±4.
